// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default baud constants
// used by both the receive and transmit controllers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // 50 MHz system clock, 115200 baud, 16x oversampling
  localparam int unsigned DEF_CLK_DIV    = 27;
  localparam int unsigned DEF_OVERSAMPLE = 16;
  localparam int unsigned DEF_DATA_BITS  = 8;

endpackage

// File: rtl/counter.sv
// Free-running modulo counter used as a tick generator. Held at zero while
// disabled so the first tick lands MODULET clocks after enable.
module counter #(
  parameter int unsigned MODULET = 27
) (
  input  logic clock,
  input  logic nreset,
  input  logic ena,
  output logic counting_done
);

  localparam int unsigned CW = (MODULET > 1) ? $clog2(MODULET) : 1;
  localparam logic [CW-1:0] LAST = CW'(MODULET - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // next count: clear when disabled, wrap at terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (!ena || (cnt_q == LAST)) cnt_d = '0;
    else                         cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign counting_done = ena && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller. Frames one async character (start, data LSB-first,
// optional parity, one stop bit) using the tick counter for bit timing and
// hands words to the host over a valid/ready handshake.
//
//  state  | meaning
//  IDLE   | line idle, waiting for a falling edge on rx_s
//  START  | timing to mid start bit to reject glitches
//  DATA   | sampling data bits at mid-bit
//  PARITY | sampling the parity bit
//  STOP   | sampling the stop bit, then delivering the word
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          HAS_PAR = (PARITY_EN != 0);
  localparam logic          ODD_PAR = (PARITY_ODD != 0);

  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;
  logic rx_prev_q, rx_prev_d;

  rx_state_t state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic tick_ena, tick, mid_pt, bit_pt;

  assign tick_ena = (state_q != IDLE);

  counter #(.MODULET(CLK_DIV)) u_tick (
    .clock         (clock),
    .nreset        (nreset),
    .ena           (tick_ena),
    .counting_done (tick)
  );

  assign mid_pt = tick && (s_cnt_q == S_MID);
  assign bit_pt = tick && (s_cnt_q == S_LAST);

  // two-flop synchronizer plus one-cycle delayed copy for edge detection
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
  end

  // frame sequencing, sampling and host-side delivery
  always_comb begin
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        s_cnt_d = '0;
        if (rx_prev_q && !rx_s_q) state_d = START;
      end
      START: begin
        if (mid_pt) begin
          s_cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end else if (tick) begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_pt) begin
          s_cnt_d = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == B_LAST) state_d = HAS_PAR ? PARITY : STOP;
          else                 bit_d   = bit_q + 1'b1;
        end else if (tick) begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_pt) begin
          s_cnt_d = '0;
          perr_d  = (^shift_q) ^ rx_s_q ^ ODD_PAR;
          state_d = STOP;
        end else if (tick) begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_pt) begin
          s_cnt_d = '0;
          state_d = IDLE;
          // a held word that the host is releasing this cycle may be replaced
          if (!rx_valid_q || rx_ready) begin
            rx_data_d    = shift_q;
            frame_err_d  = !rx_s_q;
            parity_err_d = HAS_PAR ? perr_q : 1'b0;
            rx_valid_d   = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (tick) begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        s_cnt_d = '0;
      end
    endcase
  end

  // synchronizer registers, idle-high after reset
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  // FSM, sampling and output registers
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      s_cnt_q      <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_cnt_q      <= s_cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: one instance without parity, one with even parity.
module tb_uart_rx_ctrl;

  localparam int BIT = 64;   // CLK_DIV=4 x OVERSAMPLE=16

  logic       clock = 1'b0;
  logic       nreset, rx, rx_p, rx_ready;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, frame_err, parity_err, overrun, busy;
  logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  uart_rx_ctrl #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clock(clock), .nreset(nreset), .rx(rx), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  uart_rx_ctrl #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clock(clock), .nreset(nreset), .rx(rx_p), .rx_ready(rx_ready),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .frame_err(frame_err_p),
    .parity_err(parity_err_p), .overrun(overrun_p), .busy(busy_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit which, input logic v);
    if (which) rx_p = v;
    else       rx   = v;
    repeat (BIT) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input bit has_par,
                            input bit par, input bit stop);
    drive(which, 1'b0);
    for (int i = 0; i < 8; i++) drive(which, d[i]);
    if (has_par) drive(which, par);
    drive(which, stop);
  endtask

  // n = negedge index (from call) where rx_valid is first seen, -1 on timeout
  task automatic wait_valid(input bit which, output int n, output logic [7:0] d,
                            output logic fe, output logic pe, output logic v_next,
                            output logic b);
    n = -1; d = '0; fe = 0; pe = 0; v_next = 0; b = 0;
    for (int i = 1; i <= 800; i++) begin
      @(negedge clock);
      if (which ? rx_valid_p : rx_valid) begin
        n  = i;
        d  = which ? rx_data_p    : rx_data;
        fe = which ? frame_err_p  : frame_err;
        pe = which ? parity_err_p : parity_err;
        b  = which ? busy_p       : busy;
        @(negedge clock);
        v_next = which ? rx_valid_p : rx_valid;
        break;
      end
    end
  endtask

  int         n, cnt, ovr;
  logic [7:0] d, d611, d612;
  logic       fe, pe, vn, b, v611, v612;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nreset = 1'b0; rx = 1'b1; rx_p = 1'b1; rx_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p_out", {rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p}, 0);
    @(posedge clock); #2 nreset = 1'b1;
    repeat (5) @(posedge clock);

    // 1: basic frame, latency and handshake
    rx_ready = 1'b1;
    @(posedge clock); #1;
    fork
      send_frame(0, 8'h55, 0, 0, 1);
      wait_valid(0, n, d, fe, pe, vn, b);
    join
    chk("t1_latency", n, 612);
    chk("t1_data", d, 8'h55);
    chk("t1_ferr", fe, 0);
    chk("t1_perr", pe, 0);
    chk("t1_valid_drop", vn, 0);
    chk("t1_busy", b, 0);

    // 2: start glitch aborts
    @(posedge clock); #1 rx = 1'b0;
    repeat (10) @(negedge clock);
    chk("t2_busy_start", busy, 1);
    repeat (10) @(posedge clock);
    #1 rx = 1'b1;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (rx_valid) cnt++;
    end
    chk("t2_no_valid", cnt, 0);
    chk("t2_busy_end", busy, 0);

    // 3: framing error, line held low afterwards
    @(posedge clock); #1;
    fork
      send_frame(0, 8'hA3, 0, 0, 0);
      wait_valid(0, n, d, fe, pe, vn, b);
    join
    chk("t3_latency", n, 612);
    chk("t3_data", d, 8'hA3);
    chk("t3_ferr", fe, 1);
    cnt = 0;
    for (int i = 0; i < 3 * BIT; i++) begin
      @(negedge clock);
      if (rx_valid || busy) cnt++;
    end
    chk("t3_no_rearm", cnt, 0);
    #1 rx = 1'b1;
    repeat (20) @(posedge clock);

    // 4: even parity instance
    @(posedge clock); #1;
    fork
      send_frame(1, 8'h07, 1, 0, 1);
      wait_valid(1, n, d, fe, pe, vn, b);
    join
    chk("t4a_latency", n, 676);
    chk("t4a_data", d, 8'h07);
    chk("t4a_perr", pe, 1);
    chk("t4a_ferr", fe, 0);
    @(posedge clock); #1;
    fork
      send_frame(1, 8'h07, 1, 1, 1);
      wait_valid(1, n, d, fe, pe, vn, b);
    join
    chk("t4b_data", d, 8'h07);
    chk("t4b_perr", pe, 0);

    // 5: overrun, then replacement in the completion cycle
    rx_ready = 1'b0;
    @(posedge clock); #1;
    fork
      send_frame(0, 8'h11, 0, 0, 1);
      wait_valid(0, n, d, fe, pe, vn, b);
    join
    chk("t5_first_data", d, 8'h11);
    chk("t5_first_hold", vn, 1);
    @(posedge clock); #1;
    fork
      send_frame(0, 8'h22, 0, 0, 1);
      begin
        ovr = 0;
        repeat (700) begin
          @(negedge clock);
          if (overrun) ovr++;
        end
      end
    join
    chk("t5_ovr_pulses", ovr, 1);
    chk("t5_kept_data", rx_data, 8'h11);
    chk("t5_kept_valid", rx_valid, 1);
    @(posedge clock); #1;
    fork
      send_frame(0, 8'h33, 0, 0, 1);
      begin
        repeat (610) @(posedge clock);
        #1 rx_ready = 1'b1;
        @(posedge clock);
        #1 rx_ready = 1'b0;
      end
      begin
        ovr = 0; v611 = 0; v612 = 0; d611 = 0; d612 = 0;
        for (int i = 1; i <= 700; i++) begin
          @(negedge clock);
          if (overrun) ovr++;
          if (i == 611) begin v611 = rx_valid; d611 = rx_data; end
          if (i == 612) begin v612 = rx_valid; d612 = rx_data; end
        end
      end
    join
    chk("t5_pre_valid", v611, 1);
    chk("t5_pre_data", d611, 8'h11);
    chk("t5_new_valid", v612, 1);
    chk("t5_new_data", d612, 8'h33);
    chk("t5_no_ovr", ovr, 0);

    // 6: reset during data bit 4, then a clean frame
    @(posedge clock); #1;
    fork
      send_frame(0, 8'hF0, 0, 0, 1);
      begin
        repeat (352) @(posedge clock);
        #3;
        chk("t6_pre_valid", rx_valid, 1);
        chk("t6_pre_busy", busy, 1);
        nreset = 1'b0;
        #1;
        chk("t6_rst_valid", rx_valid, 0);
        chk("t6_rst_data", rx_data, 0);
        chk("t6_rst_busy", busy, 0);
        repeat (2) @(posedge clock);
        #3 nreset = 1'b1;
      end
    join
    rx_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (rx_valid || busy) cnt++;
    end
    chk("t6_no_partial", cnt, 0);
    @(posedge clock); #1;
    fork
      send_frame(0, 8'hC6, 0, 0, 1);
      wait_valid(0, n, d, fe, pe, vn, b);
    join
    chk("t6_latency", n, 612);
    chk("t6_data", d, 8'hC6);
    chk("t6_flags", {fe, pe}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
